calib_stream_encoder: RTL and testbench

//  Token-to-ASCII transmitter for the calibration character stream; the producer end of the run/char interface.

---
 rtl/calib_stream_encoder_pkg.sv | 51 +++++
 rtl/calib_stream_encoder_digit_word_rom.sv | 34 +++
 rtl/calib_stream_encoder.sv | 153 +++++++++++++++
 tb/tb_calib_stream_encoder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/calib_stream_encoder_pkg.sv
// Shared types and constants for the calibration character stream encoder.
//   tok_kind_t  : token kind on the input interface
//   enc_state_t : encoder FSM states
//   tok_t       : captured token payload
//   WORD_ROM    : spelled-out digit words, lowercase, left-justified in 40 bits
//   WORD_LEN    : character count of each word
package calib_stream_encoder_pkg;

  localparam int unsigned CHAR_W  = 8;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned WORD_W  = 40;
  localparam int unsigned N_WORDS = 10;

  typedef enum logic [1:0] {
    TK_DIGIT = 2'd0,
    TK_WORD  = 2'd1,
    TK_RAW   = 2'd2
  } tok_kind_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CHAR = 2'd1,
    S_NL   = 2'd2,
    S_FILL = 2'd3
  } enc_state_t;

  typedef struct packed {
    tok_kind_t           kind;
    logic [DIGIT_W-1:0]  digit;
    logic [CHAR_W-1:0]   chr;
    logic                eol;   // last is folded into eol at capture
    logic                last;
  } tok_t;

  localparam logic [0:N_WORDS-1][WORD_W-1:0] WORD_ROM = {
    {"zero",  8'h00}, {"one",  16'h0000}, {"two", 16'h0000}, {"three"},
    {"four",  8'h00}, {"five",  8'h00},   {"six", 16'h0000}, {"seven"},
    {"eight"},        {"nine",  8'h00}
  };

  localparam logic [0:N_WORDS-1][IDX_W-1:0] WORD_LEN = {
    3'd4, 3'd3, 3'd3, 3'd5, 3'd4, 3'd4, 3'd3, 3'd5, 3'd5, 3'd4
  };

  // Digit values 10..15 are illegal for DIGIT and WORD tokens.
  function automatic logic digit_ok(input logic [DIGIT_W-1:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/calib_stream_encoder_digit_word_rom.sv
// Combinational digit-word lookup.
//   i_digit  : digit 0..9 (out-of-range maps to word zero; caller substitutes fill)
//   i_idx    : character position within the word
//   o_char_c : ASCII character at that position
//   o_len_c  : word length in characters
module calib_stream_encoder_digit_word_rom
  import calib_stream_encoder_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  input  logic [IDX_W-1:0]   i_idx,
  output logic [CHAR_W-1:0]  o_char_c,
  output logic [IDX_W-1:0]   o_len_c
);

  logic [DIGIT_W-1:0] w_digit;
  logic [WORD_W-1:0]  w_word;

  assign w_digit = digit_ok(i_digit) ? i_digit : 4'd0;
  assign w_word  = WORD_ROM[w_digit];
  assign o_len_c = WORD_LEN[w_digit];

  // Words are left-justified: index 0 is the top byte.
  always_comb begin
    o_char_c = w_word[7:0];
    case (i_idx)
      3'd0:    o_char_c = w_word[39:32];
      3'd1:    o_char_c = w_word[31:24];
      3'd2:    o_char_c = w_word[23:16];
      3'd3:    o_char_c = w_word[15:8];
      default: o_char_c = w_word[7:0];
    endcase
  end

endmodule

// File: rtl/calib_stream_encoder.sv
// Token-to-ASCII transmitter for the calibration character stream.
//   clk_i, rstn_i          : clock, async active-low reset
//   tok_valid_i/ready_o    : token handshake (accept on edge when both high)
//   tok_kind/digit/char_i  : token payload; tok_eol_i / tok_last_i line and stream end
//   run_o, char_o          : one ASCII char per cycle while run_o is high
//   underflow_o            : saturating count of starvation fill chars
//   err_o                  : sticky flag, digit > 9 received
module calib_stream_encoder
  import calib_stream_encoder_pkg::*;
#(
  parameter logic [7:0]  FILL_CHAR = "x",
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             tok_valid_i,
  output logic             tok_ready_o,
  input  logic [1:0]       tok_kind_i,
  input  logic [3:0]       tok_digit_i,
  input  logic [7:0]       tok_char_i,
  input  logic             tok_eol_i,
  input  logic             tok_last_i,
  output logic             run_o,
  output logic [7:0]       char_o,
  output logic [CNT_W-1:0] underflow_o,
  output logic             err_o
);

  enc_state_t         r_state;
  tok_t               r_tok;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_len;

  enc_state_t         w_nxt_state;
  tok_t               w_nxt_tok;
  logic [IDX_W-1:0]   w_nxt_idx;
  logic [IDX_W-1:0]   w_nxt_len;
  logic [CHAR_W-1:0]  w_nxt_char;
  logic               w_nxt_ready;
  logic               w_load;
  logic               w_bad;
  logic               w_accept;
  logic               w_last_char;
  logic [CHAR_W-1:0]  w_rom_char;
  logic [IDX_W-1:0]   w_rom_len;

  assign w_accept    = tok_valid_i & tok_ready_o;
  assign w_last_char = (IDX_W'(r_idx + 3'd1) == r_len);

  // Next-state and token capture.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_tok   = r_tok;
    w_nxt_idx   = r_idx;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: w_load = w_accept;
      S_CHAR: begin
        if (!w_last_char)   w_nxt_idx = IDX_W'(r_idx + 3'd1);
        else if (r_tok.eol) w_nxt_state = S_NL;
        else if (w_accept)  w_load = 1'b1;
        else                w_nxt_state = S_FILL;
      end
      S_NL: begin
        if (r_tok.last)     w_nxt_state = S_IDLE;
        else if (w_accept)  w_load = 1'b1;
        else                w_nxt_state = S_FILL;
      end
      S_FILL: w_load = w_accept;
      default: w_nxt_state = S_IDLE;
    endcase
    if (w_load) begin
      w_nxt_state     = S_CHAR;
      w_nxt_idx       = '0;
      w_nxt_tok.kind  = tok_kind_t'(tok_kind_i);
      w_nxt_tok.digit = tok_digit_i;
      w_nxt_tok.chr   = tok_char_i;
      w_nxt_tok.eol   = tok_eol_i | tok_last_i;
      w_nxt_tok.last  = tok_last_i;
    end
  end

  // ROM is addressed with next-cycle values so char_o can be registered.
  calib_stream_encoder_digit_word_rom u_rom (
    .i_digit  (w_nxt_tok.digit),
    .i_idx    (w_nxt_idx),
    .o_char_c (w_rom_char),
    .o_len_c  (w_rom_len)
  );

  // Next registered outputs, derived from the next state.
  always_comb begin
    w_bad       = ((w_nxt_tok.kind == TK_DIGIT) || (w_nxt_tok.kind == TK_WORD)) &&
                  !digit_ok(w_nxt_tok.digit);
    w_nxt_len   = (w_nxt_tok.kind == TK_WORD && !w_bad) ? w_rom_len : 3'd1;
    w_nxt_char  = '0;
    w_nxt_ready = 1'b1;
    case (w_nxt_state)
      S_IDLE: begin
        w_nxt_char  = '0;
        w_nxt_ready = 1'b1;
      end
      S_CHAR: begin
        if (w_bad)                          w_nxt_char = FILL_CHAR;
        else if (w_nxt_tok.kind == TK_DIGIT) w_nxt_char = CHAR_W'(8'h30 + {4'h0, w_nxt_tok.digit});
        else if (w_nxt_tok.kind == TK_WORD)  w_nxt_char = w_rom_char;
        else                                 w_nxt_char = w_nxt_tok.chr;
        // Ready only on a token's final char with no newline to follow.
        w_nxt_ready = (IDX_W'(w_nxt_idx + 3'd1) == w_nxt_len) && !w_nxt_tok.eol;
      end
      S_NL: begin
        w_nxt_char  = 8'h0A;
        w_nxt_ready = !w_nxt_tok.last;
      end
      S_FILL: begin
        w_nxt_char  = FILL_CHAR;
        w_nxt_ready = 1'b1;
      end
      default: begin
        w_nxt_char  = '0;
        w_nxt_ready = 1'b1;
      end
    endcase
  end

  // State, token and output registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= S_IDLE;
      r_tok       <= '0;
      r_idx       <= '0;
      r_len       <= 3'd1;
      tok_ready_o <= 1'b1;
      run_o       <= 1'b0;
      char_o      <= '0;
      underflow_o <= '0;
      err_o       <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_tok       <= w_nxt_tok;
      r_idx       <= w_nxt_idx;
      r_len       <= w_nxt_len;
      tok_ready_o <= w_nxt_ready;
      run_o       <= (w_nxt_state != S_IDLE);
      char_o      <= w_nxt_char;
      if (w_nxt_state == S_FILL && underflow_o != {CNT_W{1'b1}})
        underflow_o <= CNT_W'(underflow_o + 1'b1);
      if (w_load && w_bad)
        err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_calib_stream_encoder.sv
// Directed bench for calib_stream_encoder: drives tokens, captures the char stream.
module tb_calib_stream_encoder;
  import calib_stream_encoder_pkg::*;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        tok_valid_i;
  logic        tok_ready_o;
  logic [1:0]  tok_kind_i;
  logic [3:0]  tok_digit_i;
  logic [7:0]  tok_char_i;
  logic        tok_eol_i;
  logic        tok_last_i;
  logic        run_o;
  logic [7:0]  char_o;
  logic [15:0] underflow_o;
  logic        err_o;

  int n_chk = 0;
  int n_err = 0;
  byte unsigned q_ch[$];
  bit           q_rdy[$];

  always #5 clk_i = ~clk_i;

  calib_stream_encoder #(.FILL_CHAR("x"), .CNT_W(16)) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .tok_valid_i (tok_valid_i),
    .tok_ready_o (tok_ready_o),
    .tok_kind_i  (tok_kind_i),
    .tok_digit_i (tok_digit_i),
    .tok_char_i  (tok_char_i),
    .tok_eol_i   (tok_eol_i),
    .tok_last_i  (tok_last_i),
    .run_o       (run_o),
    .char_o      (char_o),
    .underflow_o (underflow_o),
    .err_o       (err_o)
  );

  // Stream capture, sampled away from the active edge.
  always @(negedge clk_i) begin
    if (run_o) begin
      q_ch.push_back(char_o);
      q_rdy.push_back(tok_ready_o);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [3:0] d, input logic [7:0] c,
                      input logic eol, input logic last);
    int cyc = 0;
    tok_valid_i = 1'b1;
    tok_kind_i  = k;
    tok_digit_i = d;
    tok_char_i  = c;
    tok_eol_i   = eol;
    tok_last_i  = last;
    @(negedge clk_i);
    while (!tok_ready_o && cyc < 50) begin
      @(negedge clk_i);
      cyc++;
    end
    if (!tok_ready_o) chk("push_ready_timeout", 32'(tok_ready_o), 32'd1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int cyc = 0;
    tok_valid_i = 1'b0;
    @(negedge clk_i);
    while (run_o && cyc < 40) begin
      @(negedge clk_i);
      cyc++;
    end
    chk({tag, "_idle"}, 32'(run_o), 32'd0);
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_str(input string tag, input string exp);
    chk({tag, "_len"}, 32'(q_ch.size()), 32'(exp.len()));
    for (int i = 0; i < exp.len(); i++)
      if (i < q_ch.size()) chk($sformatf("%s_ch%0d", tag, i), 32'(q_ch[i]), 32'(exp[i]));
  endtask

  task automatic chk_rdy(input string tag, input int idx, input bit exp);
    if (idx < q_rdy.size()) chk($sformatf("%s_rdy%0d", tag, idx), 32'(q_rdy[idx]), 32'(exp));
    else chk($sformatf("%s_rdy%0d_missing", tag, idx), 32'(q_rdy.size()), 32'(idx + 1));
  endtask

  task automatic do_reset();
    tok_valid_i = 1'b0;
    rstn_i = 1'b0;
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    q_ch.delete();
    q_rdy.delete();
  endtask

  initial begin
    string lines[4];
    string s;
    byte   c;
    int    first, lastd, sum;

    rstn_i = 1'b0;
    tok_valid_i = 1'b0; tok_kind_i = '0; tok_digit_i = '0; tok_char_i = '0;
    tok_eol_i = 1'b0; tok_last_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_run",   32'(run_o),       32'd0);
    chk("rst_char",  32'(char_o),      32'd0);
    chk("rst_uf",    32'(underflow_o), 32'd0);
    chk("rst_err",   32'(err_o),       32'd0);
    chk("rst_ready", 32'(tok_ready_o), 32'd1);
    rstn_i = 1'b1;
    @(posedge clk_i);
    #1;

    // 1: digits and raw bytes, back to back
    q_ch.delete(); q_rdy.delete();
    push(TK_DIGIT, 4'd1, 8'h00, 1'b0, 1'b0);
    push(TK_RAW,   4'd0, "a",   1'b0, 1'b0);
    push(TK_RAW,   4'd0, "b",   1'b0, 1'b0);
    push(TK_RAW,   4'd0, "c",   1'b0, 1'b0);
    push(TK_DIGIT, 4'd2, 8'h00, 1'b0, 1'b1);
    wait_idle("t1");
    chk_str("t1", "1abc2\n");
    for (int i = 0; i < 4; i++) chk_rdy("t1", i, 1'b1);
    chk_rdy("t1", 4, 1'b0);
    chk_rdy("t1", 5, 1'b0);
    chk("t1_uf", 32'(underflow_o), 32'd0);

    // 2: spelled word followed by a digit
    q_ch.delete(); q_rdy.delete();
    push(TK_WORD,  4'd7, 8'h00, 1'b0, 1'b0);
    push(TK_DIGIT, 4'd3, 8'h00, 1'b0, 1'b1);
    wait_idle("t2");
    chk_str("t2", "seven3\n");
    for (int i = 0; i < 4; i++) chk_rdy("t2", i, 1'b0);
    chk_rdy("t2", 4, 1'b1);
    chk_rdy("t2", 6, 1'b0);

    // 3: sample lines decoded by a first/last-digit sink
    lines[0] = "1abc2"; lines[1] = "pqr3stu8vwx";
    lines[2] = "a1b2c3d4e5f"; lines[3] = "treb7uchet";
    q_ch.delete(); q_rdy.delete();
    for (int l = 0; l < 4; l++) begin
      s = lines[l];
      for (int i = 0; i < s.len(); i++) begin
        c = s[i];
        if (c >= "0" && c <= "9")
          push(TK_DIGIT, 4'(c - 8'd48), 8'h00, i == s.len() - 1, (l == 3) && (i == s.len() - 1));
        else
          push(TK_RAW, 4'd0, 8'(c), i == s.len() - 1, (l == 3) && (i == s.len() - 1));
      end
    end
    wait_idle("t3");
    sum = 0; first = -1; lastd = 0;
    foreach (q_ch[i]) begin
      if (q_ch[i] == 8'h0A) begin
        if (first >= 0) sum += first * 10 + lastd;
        first = -1;
      end else if (q_ch[i] >= 8'h30 && q_ch[i] <= 8'h39) begin
        if (first < 0) first = q_ch[i] - 8'h30;
        lastd = q_ch[i] - 8'h30;
      end
    end
    chk("t3_nchars", 32'(q_ch.size()), 32'd41);
    chk("t3_sum",    32'(sum),         32'd142);
    chk("t3_uf",     32'(underflow_o), 32'd0);

    // 4: starvation for two cycles mid-line
    do_reset();
    push(TK_DIGIT, 4'd1, 8'h00, 1'b0, 1'b0);
    tok_valid_i = 1'b0;
    repeat (2) begin
      @(posedge clk_i);
      #1;
    end
    push(TK_DIGIT, 4'd2, 8'h00, 1'b0, 1'b1);
    wait_idle("t4");
    chk_str("t4", "1xx2\n");
    chk("t4_uf", 32'(underflow_o), 32'd2);

    // 5: illegal digit, sticky error
    do_reset();
    push(TK_DIGIT, 4'd12, 8'h00, 1'b1, 1'b0);
    push(TK_DIGIT, 4'd4,  8'h00, 1'b0, 1'b1);
    wait_idle("t5");
    chk_str("t5", "x\n4\n");
    chk("t5_err", 32'(err_o),       32'd1);
    chk("t5_uf",  32'(underflow_o), 32'd0);
    push(TK_RAW, 4'd0, "q", 1'b0, 1'b1);
    wait_idle("t5b");
    chk("t5_err_sticky", 32'(err_o), 32'd1);

    // 6: async reset in the middle of a word
    do_reset();
    chk("t6_err_clr", 32'(err_o), 32'd0);
    push(TK_WORD, 4'd8, 8'h00, 1'b0, 1'b1);
    tok_valid_i = 1'b0;
    repeat (2) begin
      @(posedge clk_i);
      #1;
    end
    chk("t6_third", 32'(char_o), 32'("g"));
    rstn_i = 1'b0;
    #1;
    chk("t6_rst_run",  32'(run_o),  32'd0);
    chk("t6_rst_char", 32'(char_o), 32'd0);
    chk_str("t6_pre", "ei");
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    q_ch.delete(); q_rdy.delete();
    chk("t6_ready", 32'(tok_ready_o), 32'd1);
    push(TK_DIGIT, 4'd5, 8'h00, 1'b0, 1'b1);
    wait_idle("t6");
    chk_str("t6", "5\n");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
